// File: rtl/iterative_integer_divider.sv
// Multicycle restoring divider, signed/unsigned, BITS_PER_CYCLE quotient bits per cycle.
// Optional INTEGER_DIVIDER_EARLY_OUT_EN adds a PREP-time |dividend| < |divisor| shortcut.
module iterative_integer_divider #(
   parameter int OPERAND_WIDTH_IN_BITS = 64,
   parameter int BITS_PER_CYCLE        = 1
) (
   input  logic                             clk_in,
   input  logic                             reset_in,
   input  logic                             valid_in,
   input  logic                             signed_in,
   input  logic [OPERAND_WIDTH_IN_BITS-1:0] dividend_in,
   input  logic [OPERAND_WIDTH_IN_BITS-1:0] divisor_in,
   output logic                             issue_ack_out,
   output logic                             valid_out,
   output logic [OPERAND_WIDTH_IN_BITS-1:0] quotient_out,
   output logic [OPERAND_WIDTH_IN_BITS-1:0] remainder_out,
   output logic                             divide_by_zero_out,
   output logic                             overflow_out,
   input  logic                             issue_ack_in
);
   localparam int W  = OPERAND_WIDTH_IN_BITS;
   localparam int N  = W / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   if (W % BITS_PER_CYCLE != 0) begin : g_bad_cfg
      $error("OPERAND_WIDTH_IN_BITS must be a multiple of BITS_PER_CYCLE");
   end

   // state | meaning
   // IDLE  | ready for a request, issue_ack_out high
   // PREP  | magnitudes, signs, special cases
   // ITER  | BITS_PER_CYCLE restoring steps per cycle
   // FIX   | apply quotient/remainder signs
   // DONE  | result held until issue_ack_in
   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_e;

   state_e         state_q, state_d;
   logic           signed_q, signed_d;
   logic [W-1:0]   dvd_q, dvd_d, dvs_q, dvs_d;
   logic [W-1:0]   dvs_mag_q, dvs_mag_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [W:0]     rem_q, rem_d;
   logic           qneg_q, qneg_d, rneg_q, rneg_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   res_q_q, res_q_d, res_r_q, res_r_d;
   logic           dbz_q, dbz_d, ovf_q, ovf_d;

   logic           dvd_neg, dvs_neg;
   logic [W-1:0]   dvd_mag, dvs_mag;
   logic [W:0]     r;
   logic [W-1:0]   q;
   logic [W+1:0]   diff;

   assign dvd_neg = signed_q & dvd_q[W-1];
   assign dvs_neg = signed_q & dvs_q[W-1];
   assign dvd_mag = dvd_neg ? (~dvd_q) + W'(1) : dvd_q;
   assign dvs_mag = dvs_neg ? (~dvs_q) + W'(1) : dvs_q;

   // quo_q starts as |dividend| and shifts out dividend bits while shifting in quotient bits
   always_comb begin
      r    = rem_q;
      q    = quo_q;
      diff = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         r    = {r[W-1:0], q[W-1]};
         q    = {q[W-2:0], 1'b0};
         diff = {1'b0, r} - {2'b00, dvs_mag_q};
         if (!diff[W+1]) begin
            r    = diff[W:0];
            q[0] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      signed_d  = signed_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      dvs_mag_d = dvs_mag_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      cnt_d     = cnt_q;
      res_q_d   = res_q_q;
      res_r_d   = res_r_q;
      dbz_d     = dbz_q;
      ovf_d     = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               signed_d = signed_in;
               dvd_d    = dividend_in;
               dvs_d    = divisor_in;
               state_d  = S_PREP;
            end
         end
         S_PREP: begin
            qneg_d    = dvd_neg ^ dvs_neg;
            rneg_d    = dvd_neg;
            dvs_mag_d = dvs_mag;
            if (dvs_q == '0) begin
               res_q_d = '1;
               res_r_d = dvd_q;
               dbz_d   = 1'b1;
               state_d = S_DONE;
            end else if (signed_q && dvd_q == {1'b1, {(W-1){1'b0}}} && dvs_q == '1) begin
               res_q_d = dvd_q;
               res_r_d = '0;
               ovf_d   = 1'b1;
               state_d = S_DONE;
            end
`ifdef INTEGER_DIVIDER_EARLY_OUT_EN
            else if (dvd_mag < dvs_mag) begin
               res_q_d = '0;
               res_r_d = dvd_q;
               state_d = S_DONE;
            end
`endif
            else begin
               rem_d   = '0;
               quo_d   = dvd_mag;
               cnt_d   = CW'(N);
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            rem_d = r;
            quo_d = q;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            res_q_d = qneg_q ? (~quo_q) + W'(1) : quo_q;
            res_r_d = rneg_q ? (~rem_q[W-1:0]) + W'(1) : rem_q[W-1:0];
            state_d = S_DONE;
         end
         S_DONE: begin
            if (issue_ack_in) begin
               dbz_d   = 1'b0;
               ovf_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q   <= S_IDLE;
         signed_q  <= 1'b0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         dvs_mag_q <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         cnt_q     <= '0;
         res_q_q   <= '0;
         res_r_q   <= '0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         signed_q  <= signed_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         dvs_mag_q <= dvs_mag_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         cnt_q     <= cnt_d;
         res_q_q   <= res_q_d;
         res_r_q   <= res_r_d;
         dbz_q     <= dbz_d;
         ovf_q     <= ovf_d;
      end
   end

   // held low during reset so no request can be taken while the core is being cleared
   assign issue_ack_out      = (state_q == S_IDLE) & ~reset_in;
   assign valid_out          = (state_q == S_DONE);
   assign quotient_out       = res_q_q;
   assign remainder_out      = res_r_q;
   assign divide_by_zero_out = dbz_q;
   assign overflow_out       = ovf_q;
endmodule

// File: tb/tb_iterative_integer_divider.sv
// Directed bench for iterative_integer_divider: one B=1 and one B=4 instance, W=64.
module tb_iterative_integer_divider;
   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         vin = 1'b0;
   logic         ack = 1'b0;
   logic         sel = 1'b0;
   logic         signed_in = 1'b0;
   logic [W-1:0] dividend = '0, divisor = '0;

   logic         ia1, v1, dz1, ov1, ia4, v4, dz4, ov4;
   logic [W-1:0] q1, r1, q4, r4;
   logic         m_ia, m_v, m_dz, m_ov;
   logic [W-1:0] m_q, m_r;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   iterative_integer_divider #(.OPERAND_WIDTH_IN_BITS(W), .BITS_PER_CYCLE(1)) dut (
      .clk_in(clk), .reset_in(rst), .valid_in(vin & ~sel), .signed_in(signed_in),
      .dividend_in(dividend), .divisor_in(divisor), .issue_ack_out(ia1), .valid_out(v1),
      .quotient_out(q1), .remainder_out(r1), .divide_by_zero_out(dz1), .overflow_out(ov1),
      .issue_ack_in(ack & ~sel));

   iterative_integer_divider #(.OPERAND_WIDTH_IN_BITS(W), .BITS_PER_CYCLE(4)) dut4 (
      .clk_in(clk), .reset_in(rst), .valid_in(vin & sel), .signed_in(signed_in),
      .dividend_in(dividend), .divisor_in(divisor), .issue_ack_out(ia4), .valid_out(v4),
      .quotient_out(q4), .remainder_out(r4), .divide_by_zero_out(dz4), .overflow_out(ov4),
      .issue_ack_in(ack & sel));

   assign m_ia = sel ? ia4 : ia1;
   assign m_v  = sel ? v4  : v1;
   assign m_dz = sel ? dz4 : dz1;
   assign m_ov = sel ? ov4 : ov1;
   assign m_q  = sel ? q4  : q1;
   assign m_r  = sel ? r4  : r1;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_div(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input logic eov, input int elat, input bit hold);
      int lat;
      @(negedge clk);
      chk({tag, "_idle"}, W'(m_ia), W'(1));
      signed_in = s; dividend = a; divisor = b; vin = 1'b1;
      @(posedge clk); #1 vin = 1'b0;
      lat = 0;
      while (!m_v && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, W'(lat), W'(elat));
      chk({tag, "_q"}, m_q, eq);
      chk({tag, "_r"}, m_r, er);
      chk({tag, "_dz"}, W'(m_dz), W'(edz));
      chk({tag, "_ov"}, W'(m_ov), W'(eov));
      if (!hold) begin
         @(negedge clk); ack = 1'b1;
         @(posedge clk); #1 ack = 1'b0;
         chk({tag, "_vclr"}, W'(m_v), W'(0));
         chk({tag, "_iaback"}, W'(m_ia), W'(1));
      end
   endtask

   initial begin
      int early_lat;
      bit seen_v;
`ifdef INTEGER_DIVIDER_EARLY_OUT_EN
      early_lat = 1;
`else
      early_lat = 66;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ia", W'(ia1), W'(0));
      chk("rst_v", W'(v1), W'(0));
      chk("rst_q", q1, '0);
      chk("rst_r", r1, '0);
      chk("rst_flags", W'({dz1, ov1}), W'(0));
      @(negedge clk); rst = 1'b0;
      #1 chk("rst_rel_ia", W'(ia1), W'(1));

      do_div("u100d7",  1'b0, W'(100), W'(7), W'(14), W'(2), 1'b0, 1'b0, 66, 1'b0);
      sel = 1'b1;
      do_div("u100d7b4", 1'b0, W'(100), W'(7), W'(14), W'(2), 1'b0, 1'b0, 18, 1'b0);
      sel = 1'b0;
      do_div("sm100d7", 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, W'(7),
             64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 66, 1'b0);
      do_div("s100dm7", 1'b1, W'(100), 64'hFFFF_FFFF_FFFF_FFF9,
             64'hFFFF_FFFF_FFFF_FFF2, W'(2), 1'b0, 1'b0, 66, 1'b0);
      do_div("u5d0", 1'b0, W'(5), W'(0), '1, W'(5), 1'b1, 1'b0, 1, 1'b0);
      do_div("s5d0", 1'b1, W'(5), W'(0), '1, W'(5), 1'b1, 1'b0, 1, 1'b0);
      do_div("sovf", 1'b1, 64'h8000_0000_0000_0000, '1,
             64'h8000_0000_0000_0000, '0, 1'b0, 1'b1, 1, 1'b0);
      do_div("uminm1", 1'b0, 64'h8000_0000_0000_0000, '1,
             '0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, early_lat, 1'b0);
      do_div("u3d10", 1'b0, W'(3), W'(10), '0, W'(3), 1'b0, 1'b0, early_lat, 1'b0);

      // backpressure with a stray request in the window
      do_div("bp", 1'b0, W'(100), W'(7), W'(14), W'(2), 1'b0, 1'b0, 66, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_v", W'(v1), W'(1));
         chk("bp_q", q1, W'(14));
         chk("bp_r", r1, W'(2));
         chk("bp_ia", W'(ia1), W'(0));
         vin = (i == 3);
         if (i == 3) begin dividend = W'(9); divisor = W'(3); end
      end
      vin = 1'b0;
      @(negedge clk); ack = 1'b1;
      @(posedge clk); #1 ack = 1'b0;
      chk("bp_ia_after", W'(ia1), W'(1));
      chk("bp_v_after", W'(v1), W'(0));
      repeat (3) @(posedge clk);
      #1 chk("bp_stray_ignored", W'(v1), W'(0));

      // reset in the middle of ITERATE
      @(negedge clk);
      signed_in = 1'b0; dividend = W'(1000); divisor = W'(10); vin = 1'b1;
      @(posedge clk); #1 vin = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mrst_v", W'(v1), W'(0));
      chk("mrst_ia", W'(ia1), W'(0));
      chk("mrst_q", q1, '0);
      chk("mrst_r", r1, '0);
      chk("mrst_flags", W'({dz1, ov1}), W'(0));
      @(negedge clk); rst = 1'b0;
      seen_v = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (v1) seen_v = 1'b1;
      end
      chk("mrst_no_valid", W'(seen_v), W'(0));
      do_div("u1000d10", 1'b0, W'(1000), W'(10), W'(100), W'(0), 1'b0, 1'b0, 66, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
